mem_arbiter: RTL
================

# mem_arbiter

Shares one single-port memory (the 512-entry RAM/ROM style array) between the processor's instruction-fetch port and its data port. Two requesters use a req/ack handshake; a sequencing FSM drives the memory's enable, write-enable, address and write data, and returns read data. The block sits between the multicycle core controller/datapath and a unified memory. It lets one physical memory back both `PC` fetches and `dAddress` loads/stores.

## Interface
- `ADDR_BITS`, 9: memory address width; `mem_addr` = request `addr[ADDR_BITS-1:0]`, upper bits ignored.
- `MEM_LATENCY`, 1: cycles from the memory sampling `mem_en` to `mem_rdata` valid; legal range 1..7.

- `clk` in 1: single clock, rising edge.
- `rst` in 1: asynchronous, active-high reset.
- `if_req` in 1: fetch request, held until `if_ack`.
- `if_addr` in 32: fetch address.
- `if_rdata` out 32: fetched word, valid while `if_ack`=1.
- `if_ack` out 1: one-cycle completion pulse.
- `d_req` in 1: data request, held until `d_ack`.
- `d_we` in 1: 1 = store, 0 = load.
- `d_addr` in 32: data address.
- `d_wdata` in 32: store data.
- `d_rdata` out 32: load data, valid while `d_ack`=1.
- `d_ack` out 1: one-cycle completion pulse.
- `mem_en` out 1: memory access strobe.
- `mem_we` out 1: memory write strobe.
- `mem_addr` out ADDR_BITS: memory address.
- `mem_wdata` out 32: memory write data.
- `mem_rdata` in 32: memory read data.
- `busy` out 1: FSM not in IDLE.

## Operation
- FSM states: IDLE, ISSUE, WAIT, RESP.
  - IDLE: arbitrate. If any req, latch winner id, addr, we and wdata, then go to ISSUE.
  - ISSUE, one cycle: `mem_en`=1; `mem_we`=latched we (always 0 for fetch). Go to RESP if write, else WAIT.
  - WAIT: 3-bit counter runs MEM_LATENCY cycles. On the last cycle, capture `mem_rdata` into `rdata_q`, then go to RESP.
  - RESP, one cycle: assert the winner's ack, then go to IDLE.
- Arbitration is two-way round-robin.
  - If only one req is high, it wins.
  - If both are high, the requester not granted last wins.
  - `last_grant` resets to FETCH, so data wins the first conflict.
- `if_rdata` and `d_rdata` both drive `rdata_q`. `rdata_q` holds until the next read capture. A store does not change it.
- Requester rules:
  - Address, we and wdata must be stable from req rise until ack.
  - req high in the cycle after ack is a new request.
  - Dropping req before grant means nothing happens.
  - Dropping req after grant: the transaction completes and ack is still pulsed.
- Only latched copies drive the memory. Input changes after grant have no effect.

## Timing
- All outputs reset to 0 and the state resets to IDLE.
- Reset asserted mid-transaction aborts it:
  - no ack is issued;
  - `mem_en`/`mem_we` drop asynchronously.
- Read: req first seen in IDLE at cycle 0. ISSUE is cycle 1, WAIT is cycles 2..1+MEM_LATENCY, ack is at cycle 2+MEM_LATENCY. With default latency, ack is at cycle 3.
- Write: ISSUE is cycle 1 with `mem_we`=1; ack is at cycle 2.
- Back-to-back reads by one requester:
  - held req gives one read per 3+MEM_LATENCY cycles;
  - held req gives one write per 3 cycles.
- Under sustained contention, grants alternate strictly. Neither requester waits more than one other transaction plus its own.
- Each transaction asserts `mem_en` exactly once. `mem_we` is only asserted in ISSUE.
- `busy`=1 in ISSUE, WAIT and RESP.

## Structure
- Shared package `mem_arb_pkg`:
  - state encoding (IDLE=0, ISSUE=1, WAIT=2, RESP=3);
  - grant ids GNT_FETCH=0, GNT_DATA=1.
- Sub-module `rr_arb2`: combinational two-way round-robin picker. Inputs are two reqs and `last_grant`; outputs are `grant_valid` and `grant_id`. The `last_grant` register lives in `mem_arbiter` and updates on the IDLE→ISSUE transition.

## Test plan
- Fetch only, if_addr=0x00400010, memory word 0x00A00093: `mem_en` at cycle 1 with `mem_addr`=0x010; `if_ack` at cycle 3 with `if_rdata`=0x00A00093; `d_ack` stays 0.
- Store with d_addr=0x24, d_wdata=0xDEADBEEF, then load from 0x24: one `mem_we` pulse; `d_ack` at cycle 2; the load returns 0xDEADBEEF.
- Both reqs held high from reset for 4 transactions: grant order is D, F, D, F. Each ack has exactly one pulse, and acks are never simultaneous.
- MEM_LATENCY=3, fetch read: ack at cycle 5. `rdata_q` is captured from `mem_rdata` at the end of cycle 4.
- `rst` asserted during WAIT: outputs are 0 immediately; no ack appears; the next request after reset is served normally.
- d_req dropped one cycle after grant, d_addr changed in ISSUE: memory still sees the latched address and `d_ack` still pulses.

Source files
------------

// File: rtl/mem_arb_pkg.sv
// Shared types for the fetch/data memory arbiter: FSM encoding and grant ids.
package mem_arb_pkg;

  typedef enum logic [1:0] {
    IDLE  = 2'd0,
    ISSUE = 2'd1,
    WAIT  = 2'd2,
    RESP  = 2'd3
  } state_t;

  typedef enum logic {
    GNT_FETCH = 1'b0,
    GNT_DATA  = 1'b1
  } gnt_t;

  localparam int DATA_W = 32;
  localparam int CNT_W  = 3;

endpackage

// File: rtl/rr_arb2.sv
// Two-way round-robin picker: a lone request wins; on a tie the requester
// that was not granted last time wins.
module rr_arb2 import mem_arb_pkg::*; (
  input  logic i_req_fetch,
  input  logic i_req_data,
  input  gnt_t i_last_grant,
  output logic o_grant_valid,
  output gnt_t o_grant_id
);

  // Pick the winner from the current requests and the grant history.
  always_comb begin
    // NOTE: every output gets a default first so no path can infer a latch.
    o_grant_valid = i_req_fetch | i_req_data;
    o_grant_id    = GNT_FETCH;
    if (i_req_fetch && i_req_data) begin
      o_grant_id = (i_last_grant == GNT_FETCH) ? GNT_DATA : GNT_FETCH;
    end else if (i_req_data) begin
      o_grant_id = GNT_DATA;
    end
  end

endmodule

// File: rtl/mem_arbiter.sv
// Shares one single-port memory between the instruction-fetch port and the
// data port. A four-state FSM issues exactly one memory access per granted
// request and returns the read word through a shared capture register.
module mem_arbiter import mem_arb_pkg::*; #(
  parameter int ADDR_BITS   = 9,
  parameter int MEM_LATENCY = 1   // legal range 1..7
) (
  input  logic                 clk,
  input  logic                 rst,
  input  logic                 if_req,
  input  logic [DATA_W-1:0]    if_addr,
  output logic [DATA_W-1:0]    if_rdata,
  output logic                 if_ack,
  input  logic                 d_req,
  input  logic                 d_we,
  input  logic [DATA_W-1:0]    d_addr,
  input  logic [DATA_W-1:0]    d_wdata,
  output logic [DATA_W-1:0]    d_rdata,
  output logic                 d_ack,
  output logic                 mem_en,
  output logic                 mem_we,
  output logic [ADDR_BITS-1:0] mem_addr,
  output logic [DATA_W-1:0]    mem_wdata,
  input  logic [DATA_W-1:0]    mem_rdata,
  output logic                 busy
);

  // Counter value on the final WAIT cycle, when mem_rdata is valid.
  localparam logic [CNT_W-1:0] LAT_LAST = CNT_W'(MEM_LATENCY - 1);

  state_t               r_state;
  state_t               w_next_state;
  gnt_t                 r_id;
  gnt_t                 r_last_grant;
  gnt_t                 w_grant_id;
  logic                 w_grant_valid;
  logic                 w_load;
  logic                 w_capture;
  logic                 r_we;
  logic [ADDR_BITS-1:0] r_addr;
  logic [DATA_W-1:0]    r_wdata;
  logic [DATA_W-1:0]    r_rdata;
  logic [CNT_W-1:0]     r_cnt;

  rr_arb2 u_rr_arb2 (
    .i_req_fetch  (if_req),
    .i_req_data   (d_req),
    .i_last_grant (r_last_grant),
    .o_grant_valid(w_grant_valid),
    .o_grant_id   (w_grant_id)
  );

  // Only the low ADDR_BITS of each request address reach the memory.
  if (ADDR_BITS < DATA_W) begin : g_addr_hi
    logic w_unused_addr_hi;
    assign w_unused_addr_hi = ^{if_addr[DATA_W-1:ADDR_BITS], d_addr[DATA_W-1:ADDR_BITS]};
  end

  // FSM state register; reset aborts any transaction in flight.
  always_ff @(posedge clk or posedge rst) begin
    // NOTE: sequential state uses non-blocking assignments so every register
    // samples the pre-edge values and updates together.
    if (rst) r_state <= IDLE;
    else     r_state <= w_next_state;
  end

  // Next-state and output decode; memory strobes come straight from state so
  // they drop the moment reset asserts.
  always_comb begin
    w_next_state = r_state;
    w_load       = 1'b0;
    w_capture    = 1'b0;
    mem_en       = 1'b0;
    mem_we       = 1'b0;
    if_ack       = 1'b0;
    d_ack        = 1'b0;
    busy         = 1'b1;
    case (r_state)
      IDLE: begin
        busy = 1'b0;
        if (w_grant_valid) begin
          w_load       = 1'b1;
          w_next_state = ISSUE;
        end
      end
      ISSUE: begin
        mem_en       = 1'b1;
        mem_we       = r_we;
        w_next_state = r_we ? RESP : WAIT;
      end
      WAIT: begin
        if (r_cnt == LAT_LAST) begin
          w_capture    = 1'b1;
          w_next_state = RESP;
        end
      end
      RESP: begin
        if_ack       = (r_id == GNT_FETCH);
        d_ack        = (r_id == GNT_DATA);
        w_next_state = IDLE;
      end
      default: w_next_state = IDLE;
    endcase
  end

  // Latch the winner's request at grant; later input changes are ignored.
  always_ff @(posedge clk or posedge rst) begin
    if (rst) begin
      r_id         <= GNT_FETCH;
      r_last_grant <= GNT_FETCH;
      r_we         <= 1'b0;
      r_addr       <= '0;
      r_wdata      <= '0;
    end else if (w_load) begin
      r_id         <= w_grant_id;
      r_last_grant <= w_grant_id;
      r_we         <= (w_grant_id == GNT_DATA) && d_we;
      r_addr       <= (w_grant_id == GNT_DATA) ? d_addr[ADDR_BITS-1:0]
                                               : if_addr[ADDR_BITS-1:0];
      r_wdata      <= (w_grant_id == GNT_DATA) ? d_wdata : '0;
    end
  end

  // Latency counter: cleared in ISSUE, counts through WAIT.
  always_ff @(posedge clk or posedge rst) begin
    if (rst)                   r_cnt <= '0;
    else if (r_state == ISSUE) r_cnt <= '0;
    else if (r_state == WAIT)  r_cnt <= r_cnt + 1'b1;
  end

  // Read-data capture; holds across stores until the next read completes.
  always_ff @(posedge clk or posedge rst) begin
    if (rst)            r_rdata <= '0;
    else if (w_capture) r_rdata <= mem_rdata;
  end

  assign mem_addr  = r_addr;
  assign mem_wdata = r_wdata;
  assign if_rdata  = r_rdata;
  assign d_rdata   = r_rdata;

endmodule
